// File: rtl/elevator_request_scheduler.sv
// LOOK-ordered elevator request scheduler: gathers floor calls into a pending
// bitmap, issues one target at a time to the motion controller and times door dwell.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  input  logic                  hold,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  direction_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  idle
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] MOVING = 2'd2;
  localparam logic [1:0] DOOR   = 2'd3;

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  // Decoded floor; out-of-range floors decode to all zeros, which drops them.
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    for (int i = 0; i < NUM_FLOORS; i++) onehot[i] = (f == FLOOR_W'(i));
  endfunction

  // Result MSB flags "found"; low bits hold the nearest pending floor above cur.
  function automatic logic [FLOOR_W:0] near_up(input logic [NUM_FLOORS-1:0] p,
                                               input logic [FLOOR_W-1:0] cur);
    near_up = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (p[i] && (FLOOR_W'(i) > cur)) near_up = {1'b1, FLOOR_W'(i)};
  endfunction

  function automatic logic [FLOOR_W:0] near_down(input logic [NUM_FLOORS-1:0] p,
                                                 input logic [FLOOR_W-1:0] cur);
    near_down = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && (FLOOR_W'(i) < cur)) near_down = {1'b1, FLOOR_W'(i)};
  endfunction

  logic [1:0]            state, state_nx;
  logic [CNT_W-1:0]      dwell_cnt, cnt_nx;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask, pending_nx, cur_oh;
  logic [FLOOR_W-1:0]    tgt_nx;
  logic                  tv_nx, dir_nx, door_nx, idle_nx;
  logic [FLOOR_W:0]      ahead, behind;

  always_comb begin
    state_nx = state;
    cnt_nx   = dwell_cnt;
    tgt_nx   = target_floor;
    tv_nx    = target_valid;
    dir_nx   = direction_up;
    door_nx  = door_open;
    clr_mask = '0;
    cur_oh   = onehot(current_floor);
    set_mask = onehot(call_floor) & {NUM_FLOORS{call_valid}};
    // The car is already standing with the door open at current_floor.
    if (state == DOOR) set_mask = set_mask & ~cur_oh;
    ahead  = direction_up ? near_up(pending, current_floor) : near_down(pending, current_floor);
    behind = direction_up ? near_down(pending, current_floor) : near_up(pending, current_floor);

    case (state)
      IDLE: begin
        if (|pending) state_nx = SELECT;
      end
      SELECT: begin
        if (pending == '0) begin
          state_nx = IDLE;
        end else if (|(pending & cur_oh)) begin
          clr_mask = cur_oh;
          state_nx = DOOR;
          door_nx  = 1'b1;
          cnt_nx   = CNT_W'(DOOR_CYCLES - 1);
        end else begin
          if (ahead[FLOOR_W]) begin
            tgt_nx = ahead[FLOOR_W-1:0];
          end else begin
            dir_nx = ~direction_up;
            tgt_nx = behind[FLOOR_W-1:0];
          end
          tv_nx    = 1'b1;
          state_nx = MOVING;
        end
      end
      MOVING: begin
        if (arrived && (current_floor == target_floor)) begin
          tv_nx    = 1'b0;
          clr_mask = onehot(target_floor);
          state_nx = DOOR;
          door_nx  = 1'b1;
          cnt_nx   = CNT_W'(DOOR_CYCLES - 1);
        end else if (ahead[FLOOR_W] &&
                     (direction_up ? (ahead[FLOOR_W-1:0] < target_floor)
                                   : (ahead[FLOOR_W-1:0] > target_floor))) begin
          tgt_nx = ahead[FLOOR_W-1:0];
        end
      end
      default: begin
        if (!hold) begin
          if (dwell_cnt == '0) begin
            door_nx  = 1'b0;
            state_nx = (|pending) ? SELECT : IDLE;
          end else begin
            cnt_nx = dwell_cnt - 1'b1;
          end
        end
      end
    endcase

    // A clear landing on a bit being set in the same cycle wins: the call is served.
    pending_nx = (pending | set_mask) & ~clr_mask;
    idle_nx    = (state_nx == IDLE) && (pending_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      dwell_cnt    <= '0;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      direction_up <= 1'b1;
      door_open    <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state        <= state_nx;
      dwell_cnt    <= cnt_nx;
      pending      <= pending_nx;
      target_floor <= tgt_nx;
      target_valid <= tv_nx;
      direction_up <= dir_nx;
      door_open    <= door_nx;
      idle         <= idle_nx;
    end
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Collects floor calls from car and hall panels into a pending-request set and sequences the elevator motion controller one target at a time. It uses LOOK ordering: continue in the current direction while calls remain ahead, then reverse. It sits upstream of the floor-stepping controller, drives its requested floor, and times door dwell on each arrival.

Parameters:
NUM_FLOORS, 8, number of served floors (2..8)
FLOOR_W, 3, floor index width
DOOR_CYCLES, 4, door-open dwell in clk cycles (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
call_valid  input  1  one-cycle call strobe
call_floor  input  FLOOR_W  floor of the call
current_floor  input  FLOOR_W  car position from the motion controller
arrived  input  1  motion controller complete flag (level)
hold  input  1  over_time OR over_weight; freezes door dwell
target_floor  output  FLOOR_W  floor requested from the motion controller
target_valid  output  1  target_floor is live
direction_up  output  1  1 = travelling/scanning up
door_open  output  1  door dwell active
pending  output  NUM_FLOORS  outstanding call bitmap
idle  output  1  state IDLE and pending == 0

Behaviour:
- Reset is synchronous, active-low: rst is sampled at posedge clk, and rst==0 resets the block.
- Reset values: state=IDLE, pending=0, target_floor=0, target_valid=0, direction_up=1, door_open=0, idle=1. Any call or dwell in progress is discarded. Reset has priority over every other input.
- All outputs are registered.
- Call capture: when call_valid=1 and call_floor<NUM_FLOORS, pending[call_floor] is set at the next edge. Calls with call_floor>=NUM_FLOORS are ignored. A duplicate call has no effect.
- If a set and a clear hit the same pending bit in the same cycle, the clear wins and the call counts as served.
- IDLE: if pending!=0, go to SELECT.
- SELECT (exactly 1 cycle):
  - If pending[current_floor]=1: clear the bit and go to DOOR.
  - Else, if any pending floor lies strictly ahead in direction_up: target_floor = nearest such floor.
  - Else: toggle direction_up and target_floor = nearest pending floor in the new direction.
  - In both of the last two cases, target_valid becomes 1 and the state goes to MOVING.
  - If pending reads 0 (after reset), go to IDLE.
- MOVING:
  - Each cycle, if a pending floor lies strictly between current_floor and target_floor in the travel direction, target_floor takes the closest such floor at the next edge (retarget).
  - When arrived=1 and current_floor==target_floor: target_valid goes to 0, pending[target_floor] is cleared, and the state goes to DOOR.
  - arrived=1 with a mismatched floor (stale complete after a retarget) is ignored.
- DOOR:
  - On entry, door_open=1 and dwell counter=DOOR_CYCLES-1.
  - While hold=1 the counter is frozen.
  - The counter decrements only when hold=0.
  - When counter==0 and hold=0: door_open goes to 0 and the state goes to SELECT if pending!=0, else IDLE.
  - door_open is therefore high for exactly DOOR_CYCLES cycles plus the number of hold-high cycles.
  - A call to current_floor during DOOR is ignored (the bit is not set).
- Timing:
  - Latency from call strobe to target_valid from IDLE: 3 edges (capture, IDLE to SELECT, SELECT to MOVING).
  - target_floor is held stable whenever target_valid=0.
- Boundaries:
  - Floors 0 and NUM_FLOORS-1 need no wrap. Direction reversal happens only in SELECT.
  - direction_up is never changed in MOVING or DOOR.
- Encoding and width:
  - Comparisons are unsigned on FLOOR_W bits.
  - The state uses 2-bit encoding: IDLE=0, SELECT=1, MOVING=2, DOOR=3.

Test Plan:
- Reset: hold rst=0 for 2 cycles with call_valid=1 and call_floor=3. Required: pending=0, target_valid=0, direction_up=1, door_open=0, idle=1.
- Single call: current_floor=0, call 5. Required: pending=8'h20 after 1 edge; target_floor=5 and target_valid=1 after 3 edges. Then drive current_floor=5 and arrived=1. Required: door_open=1 for 4 cycles, pending=0, idle=1.
- LOOK order: current_floor=2, direction_up=1, calls 6, 1 and 4 on consecutive cycles. Required: service order 4, 6, 1, with direction_up of 1, 1, 0 at each target issue.
- Retarget: target 6 from floor 1, at current_floor=2.
  - Call 3: target_floor=3 next edge.
  - Call 1 instead: target stays 6, and floor 1 is served after the reversal.
  - A stale arrived=1 at current_floor=2 produces no DOOR.
- Hold: hold=1 for 3 cycles mid-dwell. Required: door_open high for 7 cycles total; next target issued only after hold drops.
- Edge cases (NUM_FLOORS=6):
  - Call 7: ignored, pending stays 0.
  - rst=0 asserted in MOVING: everything returns to reset values on the next edge, and earlier calls are lost.
  - Call at the current floor in IDLE: SELECT goes straight to DOOR, with no target_valid pulse.
